// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns game-event pulses into timed note/rest steps
// read from a 4x8 step ROM, driving the buzzer's note_sel/sound_en inputs.
module sfx_sequencer #(
  parameter int CLK_HZ  = 12_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] trig,
  input  logic       mute,
  output logic [3:0] note_sel,
  output logic       sound_en,
  output logic       busy,
  output logic [1:0] cur_sfx
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  // Entry layout: {rest, note[3:0], dur[3:0]}; dur == 0 marks the end.
  function automatic logic [8:0] rom(input logic [1:0] sfx, input logic [2:0] step);
    logic [8:0] e;
    e = 9'h000;
    case ({sfx, step})
      5'b00_000: e = {1'b0, 4'd9,  4'd3};
      5'b00_001: e = {1'b0, 4'd7,  4'd2};
      5'b01_000: e = {1'b0, 4'd4,  4'd2};
      5'b01_001: e = {1'b0, 4'd2,  4'd2};
      5'b01_010: e = {1'b0, 4'd0,  4'd4};
      5'b10_000: e = {1'b0, 4'd0,  4'd5};
      5'b10_001: e = {1'b1, 4'd0,  4'd2};
      5'b10_010: e = {1'b0, 4'd0,  4'd5};
      5'b10_011: e = {1'b1, 4'd0,  4'd2};
      5'b10_100: e = {1'b0, 4'd0,  4'd8};
      5'b11_000: e = {1'b0, 4'd11, 4'd8};
      5'b11_001: e = {1'b0, 4'd9,  4'd8};
      5'b11_010: e = {1'b0, 4'd7,  4'd8};
      5'b11_011: e = {1'b0, 4'd4,  4'd8};
      5'b11_100: e = {1'b0, 4'd0,  4'd15};
      default:   e = 9'h000;
    endcase
    return e;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       sfx_q, sfx_d;
  logic [2:0]       step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       rem_q, rem_d;
  logic [3:0]       note_q, note_d;
  logic             rest_q, rest_d;
  logic             sound_en_q, sound_en_d;

  logic [1:0] win;
  logic       accept;
  logic [8:0] first_entry;
  logic [8:0] next_entry;

  always_comb begin
    win = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (trig[i]) win = 2'(i);
    end
    accept      = (trig != 4'd0) && ((state_q == IDLE) || (win >= sfx_q));
    first_entry = rom(win, 3'd0);
    next_entry  = rom(sfx_q, step_q + 3'd1);

    state_d = state_q;
    sfx_d   = sfx_q;
    step_d  = step_q;
    div_d   = div_q;
    rem_d   = rem_q;
    note_d  = note_q;
    rest_d  = rest_q;

    if (accept) begin
      // A new trigger always wins, including over the return to IDLE.
      state_d = PLAY;
      sfx_d   = win;
      step_d  = 3'd0;
      div_d   = '0;
      rem_d   = first_entry[3:0];
      note_d  = first_entry[7:4];
      rest_d  = first_entry[8];
    end else if (state_q == PLAY) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        if (rem_q <= 4'd1) begin
          if ((step_q == 3'd7) || (next_entry[3:0] == 4'd0)) begin
            state_d = IDLE;
            sfx_d   = 2'd0;
            step_d  = 3'd0;
            rem_d   = 4'd0;
            note_d  = 4'd0;
            rest_d  = 1'b0;
          end else begin
            step_d = step_q + 3'd1;
            rem_d  = next_entry[3:0];
            note_d = next_entry[7:4];
            rest_d = next_entry[8];
          end
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    sound_en_d = (state_d == PLAY) && !rest_d && !mute;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sfx_q      <= 2'd0;
      step_q     <= 3'd0;
      div_q      <= '0;
      rem_q      <= 4'd0;
      note_q     <= 4'd0;
      rest_q     <= 1'b0;
      sound_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sfx_q      <= sfx_d;
      step_q     <= step_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      note_q     <= note_d;
      rest_q     <= rest_d;
      sound_en_q <= sound_en_d;
    end
  end

  assign note_sel = note_q;
  assign sound_en = sound_en_q;
  assign busy     = (state_q == PLAY);
  assign cur_sfx  = sfx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random triggers, checked
// against a timeline model that derives outputs from elapsed time since accept.
module tb_sfx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] trig = 4'd0;
  logic       mute = 1'b0;
  logic [3:0] note_sel;
  logic       sound_en;
  logic       busy;
  logic [1:0] cur_sfx;

  sfx_sequencer #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .reset(reset), .trig(trig), .mute(mute),
    .note_sel(note_sel), .sound_en(sound_en), .busy(busy), .cur_sfx(cur_sfx)
  );

  always #5 clk = ~clk;

  localparam int TDIV = 10;

  int tests = 0;
  int fails = 0;

  int durs [4][8] = '{'{3, 2, 0, 0, 0, 0, 0, 0}, '{2, 2, 4, 0, 0, 0, 0, 0},
                      '{5, 2, 5, 2, 8, 0, 0, 0}, '{8, 8, 8, 8, 15, 0, 0, 0}};
  int notes[4][8] = '{'{9, 7, 0, 0, 0, 0, 0, 0}, '{4, 2, 0, 0, 0, 0, 0, 0},
                      '{0, 0, 0, 0, 0, 0, 0, 0}, '{11, 9, 7, 4, 0, 0, 0, 0}};
  int rests[4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
                      '{0, 1, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};

  int m_sfx   = 0;
  int m_start = 0;
  bit m_valid = 1'b0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Walk the step list accumulating durations to find what plays at 'el'.
  function automatic void lookup(input int sfx, input int el,
                                 output bit act, output int note, output bit rest);
    int acc;
    acc  = 0;
    act  = 1'b0;
    note = 0;
    rest = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (durs[sfx][s] == 0) break;
      if (el >= acc && el < acc + durs[sfx][s] * TDIV) begin
        act  = 1'b1;
        note = notes[sfx][s];
        rest = (rests[sfx][s] != 0);
        return;
      end
      acc += durs[sfx][s] * TDIV;
    end
  endfunction

  task automatic cycle(input logic [3:0] t, input logic m);
    bit act;
    int note;
    bit rest;
    int w;
    trig = t;
    mute = m;
    @(posedge clk);
    cyc++;
    lookup(m_sfx, cyc - 1 - m_start, act, note, rest);
    if (!m_valid) act = 1'b0;
    if (t != 4'd0) begin
      w = 0;
      for (int i = 0; i < 4; i++) if (t[i]) w = i;
      if (!act || w >= m_sfx) begin
        m_sfx   = w;
        m_start = cyc;
        m_valid = 1'b1;
      end
    end
    lookup(m_sfx, cyc - m_start, act, note, rest);
    if (!m_valid) act = 1'b0;
    #1;
    check("note_sel", note_sel, act ? note : 0);
    check("sound_en", sound_en, (act && !rest && !m) ? 1 : 0);
    check("busy", busy, act ? 1 : 0);
    check("cur_sfx", cur_sfx, act ? m_sfx : 0);
    trig = 4'd0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_note"}, note_sel, 0);
    check({tag, "_snd"}, sound_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sfx"}, cur_sfx, 0);
  endtask

  task automatic do_reset(input int hold);
    #2 reset = 1'b0;
    #1 check_zero("rst_async");
    repeat (hold) begin
      @(posedge clk);
      #1 check_zero("rst_hold");
    end
    reset   = 1'b1;
    trig    = 4'd0;
    m_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int start, input logic m, output int n);
    n = start;
    while (busy === 1'b1 && n < 1000) begin
      cycle(4'd0, m);
      if (busy === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    int r;
    logic [3:0] t;
    logic m;

    #3 check_zero("rst_init");
    repeat (2) @(posedge clk);
    #1 check_zero("rst_init_hold");
    reset = 1'b1;
    repeat (5) cycle(4'd0, 1'b0);

    // SFX0 basic timing
    cycle(4'b0001, 1'b0);
    check("sfx0_first_note", note_sel, 9);
    run_until_idle(1, 1'b0, n);
    check("sfx0_len", n, 50);

    // SFX2 with rests
    cycle(4'b0100, 1'b0);
    run_until_idle(1, 1'b0, n);
    check("sfx2_len", n, 220);

    // Pre-emption of SFX1 by SFX3, later SFX0 discarded
    cycle(4'b0010, 1'b0);
    repeat (14) cycle(4'd0, 1'b0);
    cycle(4'b1000, 1'b0);
    check("pre_note", note_sel, 11);
    check("pre_sfx", cur_sfx, 3);
    repeat (20) cycle(4'd0, 1'b0);
    cycle(4'b0001, 1'b0);
    check("discard_sfx", cur_sfx, 3);
    run_until_idle(22, 1'b0, n);
    check("sfx3_len", n, 470);

    // Simultaneous triggers, then same-priority restart
    cycle(4'b0101, 1'b0);
    check("simul_sfx", cur_sfx, 2);
    repeat (30) cycle(4'd0, 1'b0);
    cycle(4'b0100, 1'b0);
    run_until_idle(1, 1'b0, n);
    check("restart_len", n, 220);

    // Mute during SFX1 step 2
    cycle(4'b0010, 1'b0);
    repeat (44) cycle(4'd0, 1'b0);
    cycle(4'd0, 1'b1);
    check("mute_snd", sound_en, 0);
    check("mute_busy", busy, 1);
    run_until_idle(46, 1'b1, n);
    check("mute_len", n, 80);
    cycle(4'd0, 1'b0);

    // Trigger on the final cycle of a sequence wins over return to IDLE
    cycle(4'b0001, 1'b0);
    repeat (49) cycle(4'd0, 1'b0);
    cycle(4'b0010, 1'b0);
    check("last_cyc_busy", busy, 1);
    check("last_cyc_sfx", cur_sfx, 1);
    run_until_idle(1, 1'b0, n);
    check("last_cyc_len", n, 80);

    // Reset mid-SFX3
    cycle(4'b1000, 1'b0);
    repeat (100) cycle(4'd0, 1'b0);
    do_reset(3);
    repeat (5) cycle(4'd0, 1'b0);

    // Random triggers and mute
    m = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 59);
      if (r == 0)      t = 4'($urandom_range(1, 15));
      else if (r == 1) t = 4'(1 << $urandom_range(0, 3));
      else             t = 4'd0;
      if ($urandom_range(0, 49) == 0) m = ~m;
      cycle(t, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
